seg7_hex_display: RTL and testbench
===================================

// Module: seg7_hex_display
// PURPOSE
//  Multi-digit 7-segment hex display driver for the board HEX displays. Generalises the single-digit decoder.
//  - NUM_DIGITS nibbles, latched on a load strobe.
//  - Full 0-F glyph set, including a real 'F'.
//  - Per-digit blank and blink, leading-zero suppression, global PWM dimming.
//  Sits between user logic and the HEX pins. Outputs are registered, active-low, one 7-bit field per digit.
// PARAMETERS
//  NUM_DIGITS  6           number of digits driven (1..8)
//  BLINK_DIV   25_000_000  clocks per blink half-period (>=2); 0.5 s at 50 MHz
//  PWM_BITS    4           brightness resolution in bits (1..8)
// PORTS
//  clk          in   1             system clock; all logic on rising edge
//  reset_n      in   1             synchronous reset, active-low
//  load         in   1             capture value when high (sampled every clk)
//  value        in   4*NUM_DIGITS  digit nibbles; [3:0] = digit 0 = rightmost
//  lz_blank     in   1             1 = suppress leading zeros
//  blank_mask   in   NUM_DIGITS    1 = force digit dark
//  blink_en     in   NUM_DIGITS    1 = digit blinks
//  brightness   in   PWM_BITS      duty control; 0 = off, all-ones = full on
//  hex_out      out  7*NUM_DIGITS  active-low segments; [6:0] = digit 0
//  blink_phase  out  1             0 = blink-on half, 1 = blink-off half
// BEHAVIOUR
//  Segment map per digit: bit0=a top, 1=b top-right, 2=c bottom-right, 3=d bottom,
//   4=e bottom-left, 5=f top-left, 6=g middle. A 0 bit lights the segment; blank = 7'h7F.
//  Glyphs 0..F:
//   40 79 24 30 19 12 02 78 00 18 08 03 46 21 06 0E
//  Reset (reset_n low at a rising edge; overrides load and all other inputs):
//   - value_q=0, blink_cnt=0, blink_phase=0, pwm_cnt=0
//   - hex_out=all ones (every digit dark)
//  Load: if load=1 at edge N, value_q=value after edge N. A load every cycle is legal; the last one wins.
//  Output register: hex_out after edge N+1 reflects value_q and the control inputs sampled at edge N+1.
//   - Latency load->hex_out = 2 clocks.
//   - Control inputs (lz_blank, blank_mask, blink_en, brightness) -> hex_out = 1 clock.
//  Blink counter:
//   - blink_cnt counts 0..BLINK_DIV-1, wraps to 0.
//   - At the edge where blink_cnt==BLINK_DIV-1, blink_phase toggles.
//   - blink_phase runs free, independent of blink_en.
//  PWM:
//   - pwm_cnt is free-running modulo 2**PWM_BITS.
//   - pwm_on = (brightness=={PWM_BITS{1'b1}}) | (pwm_cnt < brightness).
//   - pwm_on is common to all digits.
//  Leading-zero suppression (lz_blank=1):
//   - Starting at the most significant digit, each digit whose nibble is 0 and whose higher digits are all suppressed is blanked.
//   - Digit 0 is never suppressed, so value_q=0 shows a single '0'.
//   - Suppression uses raw nibble values. A higher digit held dark by blank_mask does not stop suppression.
//  Per-digit result, highest priority first (each blanking case gives 7'h7F):
//   1. reset
//   2. blank_mask[i]
//   3. !pwm_on
//   4. blink_en[i] & blink_phase
//   5. leading-zero suppressed
//   6. glyph(value_q[4i+3:4i])
//  Counters use minimum widths:
//   - blink_cnt is $clog2(BLINK_DIV) bits and never exceeds BLINK_DIV-1.
//   - pwm_cnt is PWM_BITS bits.
//  Reset mid-blink or mid-PWM restarts both counters from 0. The first blink toggle comes BLINK_DIV clocks after reset is released.
// TESTING (NUM_DIGITS=6, BLINK_DIV=4, PWM_BITS=2 unless stated)
//  1. Reset, brightness=3, load value=24'h0123AF at one edge -> hex_out blank for 1 clk, then
//     {40,79,24,30,08,0E} digit5..0; value_q holds after load drops.
//  2. value=24'h000050, lz_blank=1 -> digits5..2 = 7F, digit1=12, digit0=40;
//     value=0 -> only digit0=40; lz_blank=0 -> all digits 40.
//  3. blink_en=6'b000001, brightness=3 -> blink_phase toggles every 4 clks;
//     digit0 alternates 4 clks glyph / 4 clks 7F; other digits steady.
//  4. brightness=1 -> digits lit exactly 1 of 4 clks; brightness=0 -> always 7F;
//     blank_mask=6'b100000 with brightness=3 -> digit5 always 7F.
//  5. Assert reset_n=0 mid-blink with load=1 -> next edge hex_out all 7F, value_q=0,
//     blink_phase=0; release -> first toggle 4 clks later.
//  6. load asserted on consecutive edges with 24'h111111 then 24'h222222 ->
//     hex_out shows 79s then 24s, each 2 clks after its load edge.

Source files
------------

// File: rtl/seg7_hex_display.sv
// Multi-digit active-low 7-segment hex driver with per-digit blank/blink,
// leading-zero suppression and global PWM dimming. All outputs registered.
module seg7_hex_display #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter int unsigned PWM_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    blink_phase
);

    localparam int unsigned BlinkW = $clog2(BLINK_DIV);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
    localparam logic [6:0] Dark = 7'h7F;

    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [BlinkW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;

    logic       pwm_on;
    logic       blink_wrap;
    logic       lz_run;
    logic [3:0] nib;
    logic [6:0] dig;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0:    glyph = 7'h40;
            4'h1:    glyph = 7'h79;
            4'h2:    glyph = 7'h24;
            4'h3:    glyph = 7'h30;
            4'h4:    glyph = 7'h19;
            4'h5:    glyph = 7'h12;
            4'h6:    glyph = 7'h02;
            4'h7:    glyph = 7'h78;
            4'h8:    glyph = 7'h00;
            4'h9:    glyph = 7'h18;
            4'hA:    glyph = 7'h08;
            4'hB:    glyph = 7'h03;
            4'hC:    glyph = 7'h46;
            4'hD:    glyph = 7'h21;
            4'hE:    glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    always_comb begin
        value_d       = load ? value : value_q;
        blink_wrap    = (blink_cnt_q == BlinkLast);
        blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q ^ blink_wrap;
        pwm_cnt_d     = pwm_cnt_q + 1'b1;
        pwm_on        = (&brightness) | (pwm_cnt_q < brightness);
        hex_d         = '1;
        nib           = '0;
        dig           = Dark;
        // Suppression chain walks down from the top digit on raw nibbles; digit 0 always breaks it.
        lz_run        = lz_blank;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            nib    = value_q[4*i +: 4];
            lz_run = lz_run && (nib == 4'h0) && (i != 0);
            if (blank_mask[i]) begin
                dig = Dark;
            end else if (!pwm_on) begin
                dig = Dark;
            end else if (blink_en[i] && blink_phase_q) begin
                dig = Dark;
            end else if (lz_run) begin
                dig = Dark;
            end else begin
                dig = glyph(nib);
            end
            hex_d[7*i +: 7] = dig;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pwm_cnt_q     <= '0;
            hex_q         <= '1;
        end else begin
            value_q       <= value_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            pwm_cnt_q     <= pwm_cnt_d;
            hex_q         <= hex_d;
        end
    end

    assign hex_out     = hex_q;
    assign blink_phase = blink_phase_q;

endmodule

// File: tb/tb_seg7_hex_display.sv
// Directed bench for seg7_hex_display (6 digits, BLINK_DIV=4, PWM_BITS=2).
module tb_seg7_hex_display;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [23:0] value;
    logic        lz_blank;
    logic [5:0]  blank_mask;
    logic [5:0]  blink_en;
    logic [1:0]  brightness;
    logic [41:0] hex_out;
    logic        blink_phase;

    int checks = 0;
    int errors = 0;

    localparam logic [41:0] ExpMain = {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E};
    localparam logic [41:0] AllDark = {6{7'h7F}};

    seg7_hex_display #(
        .NUM_DIGITS(6),
        .BLINK_DIV (4),
        .PWM_BITS  (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .value      (value),
        .lz_blank   (lz_blank),
        .blank_mask (blank_mask),
        .blink_en   (blink_en),
        .brightness (brightness),
        .hex_out    (hex_out),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load = 1'b1; value = 24'h0123AF; brightness = 2'd3;
        step();
        checks++;
        if (hex_out !== AllDark) begin
            errors++; $display("FAIL reset_hex: got %h want %h", hex_out, AllDark);
        end
        checks++;
        if (blink_phase !== 1'b0) begin
            errors++; $display("FAIL reset_phase: got %b want 0", blink_phase);
        end
        reset_n = 1'b1;
        step();
        load = 1'b0; value = 24'hFFFFFF;
        step();
        checks++;
        if (hex_out !== ExpMain) begin
            errors++; $display("FAIL load_glyphs: got %h want %h", hex_out, ExpMain);
        end
        step(); step();
        checks++;
        if (hex_out !== ExpMain) begin
            errors++; $display("FAIL load_hold: got %h want %h", hex_out, ExpMain);
        end
    endtask

    task automatic test_lz();
        logic [41:0] exp;
        load = 1'b1; value = 24'h000050; lz_blank = 1'b1;
        step();
        load = 1'b0;
        step();
        exp = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40};
        checks++;
        if (hex_out !== exp) begin
            errors++; $display("FAIL lz_50: got %h want %h", hex_out, exp);
        end
        load = 1'b1; value = 24'h000000;
        step();
        load = 1'b0;
        step();
        exp = {{5{7'h7F}}, 7'h40};
        checks++;
        if (hex_out !== exp) begin
            errors++; $display("FAIL lz_zero: got %h want %h", hex_out, exp);
        end
        lz_blank = 1'b0;
        step();
        exp = {6{7'h40}};
        checks++;
        if (hex_out !== exp) begin
            errors++; $display("FAIL lz_off: got %h want %h", hex_out, exp);
        end
    endtask

    task automatic test_blink();
        logic        exp_phase;
        logic [41:0] exp;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; load = 1'b1; value = 24'h0123AF; blink_en = 6'b000001; brightness = 2'd3;
        for (int k = 1; k <= 16; k++) begin
            step();
            load = 1'b0;
            exp_phase = ((k / 4) % 2) == 1;
            checks++;
            if (blink_phase !== exp_phase) begin
                errors++; $display("FAIL blink_phase k=%0d: got %b want %b", k, blink_phase, exp_phase);
            end
            if (k >= 2) begin
                exp = {ExpMain[41:7], ((((k - 1) / 4) % 2) == 1) ? 7'h7F : 7'h0E};
                checks++;
                if (hex_out !== exp) begin
                    errors++; $display("FAIL blink_hex k=%0d: got %h want %h", k, hex_out, exp);
                end
            end
        end
    endtask

    task automatic test_pwm();
        logic [41:0] exp;
        int lit;
        blink_en = 6'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1; load = 1'b1; value = 24'h0123AF; brightness = 2'd1;
        lit = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            load = 1'b0;
            if (k >= 2) begin
                exp = (((k - 1) % 4) == 0) ? ExpMain : AllDark;
                checks++;
                if (hex_out !== exp) begin
                    errors++; $display("FAIL pwm1 k=%0d: got %h want %h", k, hex_out, exp);
                end
                if (k <= 5 && hex_out !== AllDark) lit++;
            end
        end
        checks++;
        if (lit != 1) begin
            errors++; $display("FAIL pwm1_duty: got %0d lit of 4 want 1", lit);
        end
        brightness = 2'd0;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (hex_out !== AllDark) begin
                errors++; $display("FAIL pwm0 k=%0d: got %h want %h", k, hex_out, AllDark);
            end
        end
        brightness = 2'd3; blank_mask = 6'b100000;
        exp = {7'h7F, ExpMain[34:0]};
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (hex_out !== exp) begin
                errors++; $display("FAIL blank_mask k=%0d: got %h want %h", k, hex_out, exp);
            end
        end
        blank_mask = 6'b0;
    endtask

    task automatic test_reset_mid();
        blink_en = 6'b000001; brightness = 2'd3;
        for (int k = 0; k < 6; k++) step();
        reset_n = 1'b0; load = 1'b1; value = 24'h111111;
        step();
        checks++;
        if (hex_out !== AllDark) begin
            errors++; $display("FAIL midrst_hex: got %h want %h", hex_out, AllDark);
        end
        checks++;
        if (blink_phase !== 1'b0) begin
            errors++; $display("FAIL midrst_phase: got %b want 0", blink_phase);
        end
        reset_n = 1'b1; load = 1'b0; blink_en = 6'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                checks++;
                if (hex_out !== {6{7'h40}}) begin
                    errors++; $display("FAIL midrst_value: got %h want %h", hex_out, {6{7'h40}});
                end
            end
            checks++;
            if (blink_phase !== (k >= 4)) begin
                errors++; $display("FAIL midrst_toggle k=%0d: got %b want %b", k, blink_phase, (k >= 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        brightness = 2'd3; lz_blank = 1'b0;
        load = 1'b1; value = 24'h111111;
        step();
        checks++;
        if (hex_out !== {6{7'h40}}) begin
            errors++; $display("FAIL b2b_prev: got %h want %h", hex_out, {6{7'h40}});
        end
        value = 24'h222222;
        step();
        load = 1'b0;
        checks++;
        if (hex_out !== {6{7'h79}}) begin
            errors++; $display("FAIL b2b_first: got %h want %h", hex_out, {6{7'h79}});
        end
        step();
        checks++;
        if (hex_out !== {6{7'h24}}) begin
            errors++; $display("FAIL b2b_second: got %h want %h", hex_out, {6{7'h24}});
        end
    endtask

    initial begin
        reset_n = 1'b0; load = 1'b0; value = '0; lz_blank = 1'b0;
        blank_mask = '0; blink_en = '0; brightness = 2'd3;
        test_reset();
        test_lz();
        test_blink();
        test_pwm();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
